hex_program_loader: RTL and testbench
=====================================

Name: hex_program_loader

Overview:
- Board-side input path for the MIPS FPGA build, the write direction opposite the register/instruction display dump.
- The operator enters 32-bit instruction words as hex digits on SW[3:0] and KEY pushbuttons.
- Assembled words are written sequentially into instruction memory through a write/ack handshake.
- word_preview drives SEG7_LUT_8, so the word being typed appears on HEX7..HEX0.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles a key level must be stable before it is accepted (5 ms at CLOCK_50).
ADDR_W, 8, instruction-memory word-address width.
DIGITS, 8, hex digits per word (fixed at 8 for 32-bit words; other values are out of scope).

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  loader mode (processor held off by top level while 1)
key_digit_n  in  1  raw pushbutton, active-low: enter sw_digit
key_commit_n  in  1  raw pushbutton, active-low: write current word
sw_digit  in  4  hex digit value
mem_we  out  1  write request, held until mem_ack
mem_addr  out  ADDR_W  word address of write / next write
mem_wdata  out  32  word being written
mem_ack  in  1  memory accepted write this cycle
word_preview  out  32  current assembly buffer
digit_count  out  4  digits entered, 0..8
overflow  out  1  sticky: digit entered while 8 already held
busy  out  1  high in WRITE state

Behaviour:
- Reset (reset=0, async) clears all outputs and state: mem_we=0, mem_addr=0, mem_wdata=0, word_preview=0, digit_count=0, overflow=0, busy=0, state=ENTRY. Both debouncers take the released level (1).
- Key conditioning, per key:
  - 2-flop synchronizer, then a counter.
  - The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
  - A debounced 1->0 transition produces a single-cycle press pulse. Release produces nothing.
- FSM states: ENTRY, WRITE.
- ENTRY:
  - Digit pulse with digit_count<8: buffer={buffer[27:0], sw_digit}, digit_count+1, registered the cycle after the pulse.
  - Digit pulse with digit_count==8: buffer unchanged, overflow<=1.
  - Commit pulse with digit_count>0: the next cycle has mem_we=1, mem_wdata=buffer (right-aligned, upper digits 0 if fewer than 8 entered), state=WRITE, busy=1.
  - Commit pulse with digit_count==0: ignored.
  - Digit and commit pulse in the same cycle: commit wins and the digit is discarded.
- WRITE:
  - mem_we, mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
  - On the cycle after ack: mem_we=0, busy=0, mem_addr+1, buffer=0, digit_count=0, overflow=0, state=ENTRY.
  - Minimum write length is 1 cycle (ack in the first mem_we cycle).
  - mem_ack while mem_we=0 is ignored.
  - Key pulses during WRITE are discarded.
- Address wrap: mem_addr increments modulo 2^ADDR_W (all-ones -> 0), with no flag.
- enable=0:
  - In ENTRY: buffer, digit_count and overflow are cleared and mem_addr=0; key pulses are ignored.
  - In WRITE: the handshake completes normally, then the enable=0 clearing applies.
- word_preview equals the buffer at all times.
- Reset mid-WRITE drops mem_we to 0 asynchronously; the partial handshake is abandoned.

Decomposition:
- loader_pkg holds:
  - typedef enum logic {ENTRY, WRITE} loader_state_t
  - localparam DIGIT_W=4
  - localparam WORD_W=32
- Sub-module key_debounce (params DEBOUNCE_CYCLES; ports clk, reset, key_n, level, press), instantiated once per key.
- Top level of the loader holds the FSM, buffer and address counter.

Test Plan (DEBOUNCE_CYCLES=4, ADDR_W=8 unless stated):
1. Hold reset=0 with random inputs -> all outputs 0; release -> still 0, state ENTRY.
2. enable=1; press digits 2,0,0,8,0,0,0,5, then commit; ack asserted on the 3rd mem_we cycle -> mem_we high exactly 3 cycles with addr=0, wdata=0x20080005; the next cycle has mem_addr=1, digit_count=0, word_preview=0.
3. key_digit_n glitches low for 3 cycles (< DEBOUNCE_CYCLES) -> digit_count unchanged; a 10-cycle press -> exactly one digit, digit_count=1.
4. Enter 9 digits 1..9 -> word_preview=0x12345678, overflow=1; commit+ack -> overflow=0, wdata=0x12345678. Also: commit with digit_count=0 -> no mem_we; digits A,B then commit -> wdata=0x000000AB.
5. ADDR_W=2: four commit+ack cycles -> addresses 0,1,2,3, then mem_addr=0. Digit and commit pulses forced in the same cycle -> write happens and no digit is added.
6. Assert reset=0 mid-WRITE -> mem_we=0 in the same cycle, mem_addr=0. enable=0 during WRITE -> write completes on ack, then mem_addr=0.

Source files
------------

// File: rtl/hex_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// hex_program_loader_pkg
//
// Shared types and constants for the board-side hex program loader. The loader
// assembles 32-bit instruction words from hex digits typed on the switches and
// writes them into instruction memory one after another.
//
// Contents:
//   loader_state_t  - loader FSM state (ENTRY while typing, WRITE while the
//                     memory handshake is in flight)
//   DIGIT_W         - width of one hex digit
//   WORD_W          - width of an instruction word
//   shift_in_digit  - appends one hex digit at the low end of a word
// -----------------------------------------------------------------------------
package hex_program_loader_pkg;

    typedef enum logic {
        ENTRY = 1'b0,
        WRITE = 1'b1
    } loader_state_t;

    localparam int DIGIT_W = 4;
    localparam int WORD_W  = 32;

    // The newest digit always lands in the least significant nibble, so a
    // partially typed word reads right-aligned with leading zero digits.
    function automatic logic [WORD_W-1:0] shift_in_digit(
        input logic [WORD_W-1:0]  word,
        input logic [DIGIT_W-1:0] digit
    );
        return {word[WORD_W-DIGIT_W-1:0], digit};
    endfunction

endpackage

// File: rtl/hex_program_loader_if.sv
// -----------------------------------------------------------------------------
// hex_program_loader_if
//
// Instruction-memory write port used by the hex program loader.
//
// Signals:
//   mem_we    - write request, held until the memory acknowledges
//   mem_addr  - word address of the current / next write (ADDR_W bits)
//   mem_wdata - word being written
//   mem_ack   - memory accepted the write in this cycle
//
// Modports:
//   master - the loader (drives request, address and data)
//   slave  - the instruction memory (drives the acknowledge)
// -----------------------------------------------------------------------------
interface hex_program_loader_if #(
    parameter int ADDR_W = 8
);
    import hex_program_loader_pkg::*;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );

endinterface

// File: rtl/hex_program_loader_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Conditions one raw active-low pushbutton. The key is brought into the clock
// domain with a two-flop synchronizer, then a stability counter decides when
// the accepted level may change. A debounced press (1 -> 0) emits a single
// cycle pulse; a release emits nothing.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous reset, active low (key reads as released)
//   key_n  - raw pushbutton, active low
//   level  - debounced key level (1 = released)
//   press  - one-cycle pulse on each debounced press
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The counter tracks how many consecutive cycles the synchronized key has
    // disagreed with the accepted level. Any cycle of agreement (a glitch
    // ending) throws the count away. The cycle that completes the run flips
    // the level, and only a flip towards 0 is reported as a press.
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            count_d = '0;
        end else if (count_q == LAST_COUNT) begin
            count_d = '0;
            level_d = sync2_q;
            press_d = ~sync2_q;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Synchronizer and debounce state. Reset makes the key look released so
    // that leaving reset with a key held down needs a full stable period
    // before it registers as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            count_q <= count_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/hex_program_loader.sv
// -----------------------------------------------------------------------------
// hex_program_loader
//
// Lets the operator type 32-bit instruction words as hex digits (SW[3:0] plus
// a "digit" pushbutton) and write them into consecutive instruction-memory
// words with a "commit" pushbutton. The word being typed is shown through
// word_preview, which feeds the eight-digit seven-segment display.
//
// Ports:
//   clk          - system clock (CLOCK_50)
//   reset        - asynchronous reset, active low
//   enable       - loader mode; when low the typing state is cleared
//   key_digit_n  - raw pushbutton, active low: shift sw_digit into the word
//   key_commit_n - raw pushbutton, active low: write the current word
//   sw_digit     - hex digit value
//   mem          - instruction-memory write port (master side)
//   word_preview - current assembly buffer
//   digit_count  - digits held in the buffer, 0..DIGITS
//   overflow     - sticky: a digit was entered while the buffer was full
//   busy         - a memory write is in progress
// -----------------------------------------------------------------------------
module hex_program_loader
    import hex_program_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ADDR_W          = 8,
    parameter int DIGITS          = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                key_digit_n,
    input  logic                key_commit_n,
    input  logic [DIGIT_W-1:0]  sw_digit,
    hex_program_loader_if.master mem,
    output logic [WORD_W-1:0]   word_preview,
    output logic [3:0]          digit_count,
    output logic                overflow,
    output logic                busy
);

    localparam logic [3:0] FULL_COUNT = 4'(DIGITS);

    logic digit_press;
    logic commit_press;
    logic unused_digit_level;
    logic unused_commit_level;

    loader_state_t     state_q;
    logic [WORD_W-1:0] buffer_q;
    logic [3:0]        count_q;
    logic              overflow_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_digit_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_digit_n),
        .level (unused_digit_level),
        .press (digit_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_commit_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_commit_n),
        .level (unused_commit_level),
        .press (commit_press)
    );

    // Loader FSM. In ENTRY the debounced key pulses edit the buffer; commit
    // takes priority over a simultaneous digit so a word is never extended on
    // the way out. A commit with an empty buffer has nothing to write and is
    // dropped. In WRITE the request, address and data stay frozen until the
    // memory acknowledges; keys and enable are ignored so a started write is
    // always finished. Leaving WRITE advances the address (wrapping naturally
    // at 2^ADDR_W) and starts a fresh word. With enable low in ENTRY the
    // loader is parked: buffer cleared and the next write goes to address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ENTRY;
            buffer_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (!enable) begin
                        buffer_q   <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        addr_q     <= '0;
                    end else if (commit_press) begin
                        if (count_q != 4'd0) begin
                            we_q    <= 1'b1;
                            wdata_q <= buffer_q;
                            state_q <= WRITE;
                        end
                    end else if (digit_press) begin
                        if (count_q < FULL_COUNT) begin
                            buffer_q <= shift_in_digit(buffer_q, sw_digit);
                            count_q  <= count_q + 4'd1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        we_q       <= 1'b0;
                        addr_q     <= addr_q + ADDR_W'(1);
                        buffer_q   <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= ENTRY;
                    end
                end
                default: begin
                    state_q <= ENTRY;
                end
            endcase
        end
    end

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign word_preview = buffer_q;
    assign digit_count  = count_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == WRITE);

endmodule

// File: tb/tb_hex_program_loader.sv
// -----------------------------------------------------------------------------
// tb_hex_program_loader
//
// Directed bench for the hex program loader. A behavioural model (digit queue,
// key sample history, write flag) predicts every output each cycle; directed
// checks against hand-computed literals pin the model and the DUT together.
// -----------------------------------------------------------------------------
module tb_hex_program_loader;

    localparam int DEB = 4;
    localparam int AW  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        key_digit_n;
    logic        key_commit_n;
    logic [3:0]  sw_digit;
    logic [31:0] word_preview;
    logic [3:0]  digit_count;
    logic        overflow;
    logic        busy;

    hex_program_loader_if #(.ADDR_W(AW)) memIf ();

    hex_program_loader #(
        .DEBOUNCE_CYCLES(DEB),
        .ADDR_W         (AW),
        .DIGITS         (8)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .enable       (enable),
        .key_digit_n  (key_digit_n),
        .key_commit_n (key_commit_n),
        .sw_digit     (sw_digit),
        .mem          (memIf),
        .word_preview (word_preview),
        .digit_count  (digit_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // memory responder controls
    int   ackDelay   = 1;
    logic strayAck   = 1'b0;
    int   weCycles   = 0;
    int   weHighCount = 0;

    // writes accepted by the memory
    logic [AW-1:0] logAddr[$];
    logic [31:0]   logData[$];

    // behavioural model state
    logic [3:0]    mDigits[$];
    bit            mWriting = 1'b0;
    logic [AW-1:0] mAddr    = '0;
    logic [31:0]   mWdata   = '0;
    bit            mOvf     = 1'b0;
    logic [DEB+1:0] histD   = '1;
    logic [DEB+1:0] histC   = '1;
    bit            levD     = 1'b1;
    bit            levC     = 1'b1;
    bit            pendD    = 1'b0;
    bit            pendC    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelWord();
        logic [31:0] v = '0;
        foreach (mDigits[i]) v = (v << 4) | 32'(mDigits[i]);
        return v;
    endfunction

    // One model step: first the loader acts on the key pulses that were
    // recognised at the previous edge, then the key histories absorb this
    // edge's raw samples. A key level is accepted once the raw samples taken
    // 2..DEB+1 edges ago all disagree with the current accepted level.
    task automatic modelStep();
        bit fireD;
        bit fireC;
        if (!rst_n) begin
            mDigits.delete();
            mWriting = 1'b0;
            mAddr    = '0;
            mWdata   = '0;
            mOvf     = 1'b0;
            histD    = '1;
            histC    = '1;
            levD     = 1'b1;
            levC     = 1'b1;
            pendD    = 1'b0;
            pendC    = 1'b0;
        end else begin
            if (mWriting) begin
                if (memIf.mem_ack === 1'b1) begin
                    mWriting = 1'b0;
                    mAddr    = mAddr + 1'b1;
                    mDigits.delete();
                    mOvf     = 1'b0;
                end
            end else if (!enable) begin
                mDigits.delete();
                mOvf  = 1'b0;
                mAddr = '0;
            end else if (pendC) begin
                if (mDigits.size() > 0) begin
                    mWriting = 1'b1;
                    mWdata   = modelWord();
                end
            end else if (pendD) begin
                if (mDigits.size() < 8) mDigits.push_back(sw_digit);
                else mOvf = 1'b1;
            end
            histD = {histD[DEB:0], key_digit_n};
            histC = {histC[DEB:0], key_commit_n};
            fireD = (histD[DEB+1:2] == {DEB{~levD}});
            fireC = (histC[DEB+1:2] == {DEB{~levC}});
            if (fireD) levD = ~levD;
            if (fireC) levC = ~levC;
            pendD = fireD && !levD;
            pendC = fireC && !levC;
        end
    endtask

    // model update on every clock edge and on asynchronous reset
    initial forever begin
        @(posedge clk or negedge rst_n);
        modelStep();
    end

    // memory responder: acknowledge on the ackDelay-th cycle of a request
    // (0 means never); outside a request drive the stray-ack control
    initial forever begin
        @(negedge clk);
        if (memIf.mem_we === 1'b1) begin
            weCycles++;
            weHighCount++;
            memIf.mem_ack = (weCycles == ackDelay);
        end else begin
            weCycles = 0;
            memIf.mem_ack = strayAck;
        end
    end

    // record every accepted write
    initial forever begin
        @(posedge clk);
        if (rst_n === 1'b1 && memIf.mem_we === 1'b1 && memIf.mem_ack === 1'b1) begin
            logAddr.push_back(memIf.mem_addr);
            logData.push_back(memIf.mem_wdata);
        end
    end

    // per-cycle comparison of every output against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("cyc_mem_we",    32'(memIf.mem_we),    32'(mWriting));
            checkOutput("cyc_busy",      32'(busy),            32'(mWriting));
            checkOutput("cyc_mem_addr",  32'(memIf.mem_addr),  32'(mAddr));
            checkOutput("cyc_mem_wdata", memIf.mem_wdata,      mWdata);
            checkOutput("cyc_preview",   word_preview,         modelWord());
            checkOutput("cyc_count",     32'(digit_count),     32'(mDigits.size()));
            checkOutput("cyc_overflow",  32'(overflow),        32'(mOvf));
        end
    end

    // hold raw inputs for a number of cycles, starting right after a negedge
    task automatic applyStimulus(input logic dn, input logic cn,
                                 input logic [3:0] d, input int cycles);
        key_digit_n  = dn;
        key_commit_n = cn;
        sw_digit     = d;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pressDigit(input logic [3:0] d);
        applyStimulus(1'b0, 1'b1, d, 10);
        applyStimulus(1'b1, 1'b1, d, 10);
    endtask

    task automatic pressCommit();
        applyStimulus(1'b1, 1'b0, 4'h0, 10);
        applyStimulus(1'b1, 1'b1, 4'h0, 10);
    endtask

    task automatic checkLastWrite(input string name, input logic [AW-1:0] addr,
                                  input logic [31:0] data, input int expectSize);
        checkOutput({name, "_count"}, 32'(logAddr.size()), 32'(expectSize));
        if (logAddr.size() > 0) begin
            checkOutput({name, "_addr"},  32'(logAddr[$]), 32'(addr));
            checkOutput({name, "_wdata"}, logData[$], data);
        end
    endtask

    initial begin
        int weStart;
        logic [3:0] pattern[8];

        // 1. reset with random inputs
        rst_n        = 1'b0;
        enable       = 1'b0;
        key_digit_n  = 1'b1;
        key_commit_n = 1'b1;
        sw_digit     = 4'h0;
        repeat (6) begin
            @(negedge clk);
            enable       = 1'($urandom);
            key_digit_n  = 1'($urandom);
            key_commit_n = 1'($urandom);
            sw_digit     = 4'($urandom);
            strayAck     = 1'($urandom);
        end
        #1;
        checkOutput("reset_mem_we",  32'(memIf.mem_we), 32'h0);
        checkOutput("reset_addr",    32'(memIf.mem_addr), 32'h0);
        checkOutput("reset_wdata",   memIf.mem_wdata, 32'h0);
        checkOutput("reset_preview", word_preview, 32'h0);
        checkOutput("reset_count",   32'(digit_count), 32'h0);
        checkOutput("reset_busy",    32'(busy), 32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        enable       = 1'b0;
        key_digit_n  = 1'b1;
        key_commit_n = 1'b1;
        strayAck     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_addr",  32'(memIf.mem_addr), 32'h0);
        checkOutput("post_reset_busy",  32'(busy), 32'h0);

        // 2. typed word, ack on the third request cycle
        $display("[TB] word entry and 3-cycle write");
        enable = 1'b1;
        @(negedge clk);
        pattern = '{4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h5};
        foreach (pattern[i]) pressDigit(pattern[i]);
        checkOutput("t2_preview", word_preview, 32'h20080005);
        checkOutput("t2_count",   32'(digit_count), 32'd8);
        ackDelay = 3;
        weStart  = weHighCount;
        pressCommit();
        checkOutput("t2_we_cycles", 32'(weHighCount - weStart), 32'd3);
        checkLastWrite("t2_write", 8'h00, 32'h20080005, 1);
        checkOutput("t2_next_addr", 32'(memIf.mem_addr), 32'h1);
        checkOutput("t2_count_clr", 32'(digit_count), 32'h0);
        checkOutput("t2_preview_clr", word_preview, 32'h0);

        // 3. short glitch is rejected, long press counts once
        $display("[TB] debounce");
        ackDelay = 1;
        applyStimulus(1'b0, 1'b1, 4'h3, 3);
        applyStimulus(1'b1, 1'b1, 4'h3, 10);
        checkOutput("t3_glitch_count", 32'(digit_count), 32'h0);
        pressDigit(4'h3);
        checkOutput("t3_press_count", 32'(digit_count), 32'h1);
        checkOutput("t3_press_preview", word_preview, 32'h3);
        pressCommit();
        checkLastWrite("t3_write", 8'h01, 32'h00000003, 2);

        // 4. overflow, empty commit, stray ack, short word
        $display("[TB] overflow and short words");
        for (int i = 1; i <= 9; i++) pressDigit(4'(i));
        checkOutput("t4_preview", word_preview, 32'h12345678);
        checkOutput("t4_overflow", 32'(overflow), 32'h1);
        checkOutput("t4_count", 32'(digit_count), 32'd8);
        pressCommit();
        checkLastWrite("t4_full_write", 8'h02, 32'h12345678, 3);
        checkOutput("t4_overflow_clr", 32'(overflow), 32'h0);
        weStart = weHighCount;
        pressCommit();
        checkOutput("t4_empty_commit_we", 32'(weHighCount - weStart), 32'h0);
        checkOutput("t4_empty_commit_log", 32'(logAddr.size()), 32'd3);
        strayAck = 1'b1;
        repeat (3) @(negedge clk);
        strayAck = 1'b0;
        @(negedge clk);
        checkOutput("t4_stray_ack_addr", 32'(memIf.mem_addr), 32'h3);
        pressDigit(4'hA);
        pressDigit(4'hB);
        pressCommit();
        checkLastWrite("t4_short_write", 8'h03, 32'h000000AB, 4);

        // 5a. digit and commit in the same cycle
        $display("[TB] simultaneous digit and commit");
        pressDigit(4'h7);
        applyStimulus(1'b0, 1'b0, 4'h5, 10);
        applyStimulus(1'b1, 1'b1, 4'h5, 10);
        checkLastWrite("t5_same_cycle", 8'h04, 32'h00000007, 5);
        checkOutput("t5_same_cycle_count", 32'(digit_count), 32'h0);
        checkOutput("t5_same_cycle_addr", 32'(memIf.mem_addr), 32'h5);

        // 6a. reset in the middle of a write
        $display("[TB] reset mid-write");
        pressDigit(4'h1);
        ackDelay = 0;
        applyStimulus(1'b1, 1'b0, 4'h0, 8);
        checkOutput("t6_we_before_reset", 32'(memIf.mem_we), 32'h1);
        #2;
        rst_n        = 1'b0;
        key_commit_n = 1'b1;
        #1;
        checkOutput("t6_reset_we",   32'(memIf.mem_we), 32'h0);
        checkOutput("t6_reset_addr", 32'(memIf.mem_addr), 32'h0);
        checkOutput("t6_reset_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ackDelay = 1;
        repeat (2) @(negedge clk);
        checkOutput("t6_no_write_logged", 32'(logAddr.size()), 32'd5);

        // 6b. enable dropped during a write
        $display("[TB] enable low during write");
        pressDigit(4'h6);
        pressCommit();
        checkLastWrite("t6_first", 8'h00, 32'h00000006, 6);
        pressDigit(4'h9);
        ackDelay = 3;
        applyStimulus(1'b1, 1'b0, 4'h0, 8);
        checkOutput("t6_we_held", 32'(memIf.mem_we), 32'h1);
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h0, 2);
        applyStimulus(1'b1, 1'b1, 4'h0, 10);
        checkLastWrite("t6_disable_write", 8'h01, 32'h00000009, 7);
        checkOutput("t6_disable_addr", 32'(memIf.mem_addr), 32'h0);
        pressDigit(4'h4);
        checkOutput("t6_disabled_digit", 32'(digit_count), 32'h0);
        enable   = 1'b1;
        ackDelay = 1;
        @(negedge clk);

        // 5b. address wrap
        $display("[TB] address wrap");
        for (int i = 0; i < 255; i++) begin
            pressDigit(4'(i));
            pressCommit();
        end
        checkOutput("t5_addr_ff", 32'(memIf.mem_addr), 32'hFF);
        pressDigit(4'hC);
        pressCommit();
        checkLastWrite("t5_wrap_write", 8'hFF, 32'h0000000C, 263);
        checkOutput("t5_wrapped_addr", 32'(memIf.mem_addr), 32'h0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
